// File: rtl/cpu_datamem_arb.sv
// CPU-priority arbiter with per-accelerator request FIFOs in front of a single-ported data memory.
// Define ARB_STARVE_GUARD_EN to add the accelerator starvation counter and forced grant.
module cpu_datamem_arb #(
    parameter int NUM_ACCEL    = 2,
    parameter int ADDR_W       = 16,
    parameter int WORD_W       = 32,
    parameter int LINE_W       = 512,
    parameter int FIFO_DEPTH   = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        cpu_req,
    input  logic                        cpu_wrt_en,
    input  logic [ADDR_W-1:0]           cpu_addr,
    input  logic [WORD_W-1:0]           cpu_wrt_data,
    output logic                        cpu_stall,
    output logic                        cpu_rd_valid,
    output logic [WORD_W-1:0]           cpu_rd_data,
    input  logic [NUM_ACCEL-1:0]        accel_req,
    input  logic [NUM_ACCEL-1:0]        accel_wrt_en,
    input  logic [NUM_ACCEL*ADDR_W-1:0] accel_addr,
    input  logic [NUM_ACCEL*WORD_W-1:0] accel_wrt_data,
    output logic [NUM_ACCEL-1:0]        accel_ready,
    output logic [NUM_ACCEL-1:0]        accel_rd_valid,
    output logic [LINE_W-1:0]           accel_rd_data,
    output logic [ADDR_W-1:0]           mem_addr,
    output logic [WORD_W-1:0]           mem_wrt_data,
    output logic                        mem_wrt_en,
    output logic                        mem_rd_en,
    input  logic [LINE_W-1:0]           mem_rd_data
);
    localparam int IDX_W   = (NUM_ACCEL > 1) ? $clog2(NUM_ACCEL) : 1;
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int ENTRY_W = 1 + ADDR_W + WORD_W;

    logic [ENTRY_W-1:0]   fifo_mem_r [NUM_ACCEL][FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_r   [NUM_ACCEL];
    logic [PTR_W-1:0]     rd_ptr_r   [NUM_ACCEL];
    logic [CNT_W-1:0]     count_r    [NUM_ACCEL];
    logic [IDX_W-1:0]     rr_ptr_r;
    logic [NUM_ACCEL-1:0] not_empty_s;
    logic [NUM_ACCEL-1:0] push_s;
    logic [NUM_ACCEL-1:0] pop_s;
    logic                 any_pending_s;
    logic                 force_s;
    logic                 cpu_grant_s;
    logic                 accel_grant_s;
    logic [IDX_W-1:0]     rr_idx_s;
    logic [IDX_W:0]       cand_s;
    logic [ENTRY_W-1:0]   head_s;
    logic                 tag_valid_r;
    logic                 tag_cpu_r;
    logic [IDX_W-1:0]     tag_idx_r;

    // FIFO occupancy flags and accepted pushes
    always_comb begin
        for (int i = 0; i < NUM_ACCEL; i++) begin
            not_empty_s[i] = (count_r[i] != CNT_W'(0));
            accel_ready[i] = (count_r[i] != CNT_W'(FIFO_DEPTH));
            push_s[i]      = accel_req[i] && (count_r[i] != CNT_W'(FIFO_DEPTH));
        end
        any_pending_s = |not_empty_s;
    end

    // Round-robin search; descending scan so the candidate closest to rr_ptr_r wins
    always_comb begin
        rr_idx_s = IDX_W'(0);
        cand_s   = (IDX_W+1)'(0);
        for (int k = NUM_ACCEL - 1; k >= 0; k--) begin
            cand_s = {1'b0, rr_ptr_r} + (IDX_W+1)'(k);
            if (cand_s >= (IDX_W+1)'(NUM_ACCEL)) begin
                cand_s = cand_s - (IDX_W+1)'(NUM_ACCEL);
            end else begin
                cand_s = cand_s;
            end
            if (not_empty_s[cand_s[IDX_W-1:0]]) begin
                rr_idx_s = cand_s[IDX_W-1:0];
            end else begin
                rr_idx_s = rr_idx_s;
            end
        end
        head_s = fifo_mem_r[rr_idx_s][rd_ptr_r[rr_idx_s]];
    end

`ifdef ARB_STARVE_GUARD_EN
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    logic [SW-1:0] starve_r;

    // Consecutive cycles an accelerator head has waited without a grant
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_r <= SW'(0);
        end else if (accel_grant_s || !any_pending_s) begin
            starve_r <= SW'(0);
        end else if (starve_r != SW'(STARVE_LIMIT)) begin
            starve_r <= starve_r + SW'(1);
        end else begin
            starve_r <= starve_r;
        end
    end

    assign force_s   = any_pending_s && (starve_r == SW'(STARVE_LIMIT));
    assign cpu_stall = cpu_req && !cpu_grant_s;
`else
    assign force_s   = 1'b0;
    assign cpu_stall = 1'b0;
`endif

    // Grant selection and memory port mux
    always_comb begin
        cpu_grant_s   = 1'b0;
        accel_grant_s = 1'b0;
        mem_addr      = {ADDR_W{1'b0}};
        mem_wrt_data  = {WORD_W{1'b0}};
        mem_wrt_en    = 1'b0;
        mem_rd_en     = 1'b0;
        if (force_s) begin
            accel_grant_s = 1'b1;
        end else if (cpu_req) begin
            cpu_grant_s = 1'b1;
        end else if (any_pending_s) begin
            accel_grant_s = 1'b1;
        end else begin
            accel_grant_s = 1'b0;
        end
        if (cpu_grant_s) begin
            mem_addr     = cpu_addr;
            mem_wrt_data = cpu_wrt_data;
            mem_wrt_en   = cpu_wrt_en;
            mem_rd_en    = !cpu_wrt_en;
        end else if (accel_grant_s) begin
            mem_wrt_en   = head_s[ENTRY_W-1];
            mem_rd_en    = !head_s[ENTRY_W-1];
            mem_addr     = head_s[WORD_W +: ADDR_W];
            mem_wrt_data = head_s[WORD_W-1:0];
        end else begin
            mem_wrt_en   = 1'b0;
        end
        for (int i = 0; i < NUM_ACCEL; i++) begin
            pop_s[i] = accel_grant_s && (rr_idx_s == IDX_W'(i));
        end
    end

    // FIFO storage, no reset needed since occupancy gates every read
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_ACCEL; i++) begin
            if (push_s[i]) begin
                fifo_mem_r[i][wr_ptr_r[i]] <= {accel_wrt_en[i],
                                               accel_addr[i*ADDR_W +: ADDR_W],
                                               accel_wrt_data[i*WORD_W +: WORD_W]};
            end
        end
    end

    // FIFO pointers/counts, round-robin pointer and read-return tag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_ACCEL; i++) begin
                wr_ptr_r[i] <= PTR_W'(0);
                rd_ptr_r[i] <= PTR_W'(0);
                count_r[i]  <= CNT_W'(0);
            end
            rr_ptr_r    <= IDX_W'(0);
            tag_valid_r <= 1'b0;
            tag_cpu_r   <= 1'b0;
            tag_idx_r   <= IDX_W'(0);
        end else begin
            for (int i = 0; i < NUM_ACCEL; i++) begin
                if (push_s[i]) wr_ptr_r[i] <= wr_ptr_r[i] + PTR_W'(1);
                if (pop_s[i])  rd_ptr_r[i] <= rd_ptr_r[i] + PTR_W'(1);
                if (push_s[i] && !pop_s[i]) begin
                    count_r[i] <= count_r[i] + CNT_W'(1);
                end else if (!push_s[i] && pop_s[i]) begin
                    count_r[i] <= count_r[i] - CNT_W'(1);
                end else begin
                    count_r[i] <= count_r[i];
                end
            end
            if (accel_grant_s) begin
                rr_ptr_r <= (rr_idx_s == IDX_W'(NUM_ACCEL - 1)) ? IDX_W'(0) : rr_idx_s + IDX_W'(1);
            end
            tag_valid_r <= mem_rd_en;
            tag_cpu_r   <= cpu_grant_s;
            tag_idx_r   <= rr_idx_s;
        end
    end

    // Route the returned line to whichever requester the tag names
    always_comb begin
        cpu_rd_valid = tag_valid_r && tag_cpu_r;
        cpu_rd_data  = cpu_rd_valid ? mem_rd_data[WORD_W-1:0] : {WORD_W{1'b0}};
        for (int i = 0; i < NUM_ACCEL; i++) begin
            accel_rd_valid[i] = tag_valid_r && !tag_cpu_r && (tag_idx_r == IDX_W'(i));
        end
        accel_rd_data = (tag_valid_r && !tag_cpu_r) ? mem_rd_data : {LINE_W{1'b0}};
    end
endmodule

// File: tb/tb_cpu_datamem_arb.sv
// Directed self-checking bench for cpu_datamem_arb with a write-first line memory model.
module tb_cpu_datamem_arb;
    localparam int NA = 2;
    localparam int AW = 16;
    localparam int WW = 32;
    localparam int LW = 512;
`ifdef ARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n;
    logic             cpu_req, cpu_wrt_en;
    logic [AW-1:0]    cpu_addr;
    logic [WW-1:0]    cpu_wrt_data;
    logic             cpu_stall, cpu_rd_valid;
    logic [WW-1:0]    cpu_rd_data;
    logic [NA-1:0]    accel_req, accel_wrt_en, accel_ready, accel_rd_valid;
    logic [NA*AW-1:0] accel_addr;
    logic [NA*WW-1:0] accel_wrt_data;
    logic [LW-1:0]    accel_rd_data;
    logic [AW-1:0]    mem_addr;
    logic [WW-1:0]    mem_wrt_data;
    logic             mem_wrt_en, mem_rd_en;
    logic [LW-1:0]    mem_rd_data = '0;

    int checks = 0;
    int errors = 0;

    cpu_datamem_arb dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(cpu_req), .cpu_wrt_en(cpu_wrt_en), .cpu_addr(cpu_addr),
        .cpu_wrt_data(cpu_wrt_data), .cpu_stall(cpu_stall),
        .cpu_rd_valid(cpu_rd_valid), .cpu_rd_data(cpu_rd_data),
        .accel_req(accel_req), .accel_wrt_en(accel_wrt_en), .accel_addr(accel_addr),
        .accel_wrt_data(accel_wrt_data), .accel_ready(accel_ready),
        .accel_rd_valid(accel_rd_valid), .accel_rd_data(accel_rd_data),
        .mem_addr(mem_addr), .mem_wrt_data(mem_wrt_data), .mem_wrt_en(mem_wrt_en),
        .mem_rd_en(mem_rd_en), .mem_rd_data(mem_rd_data)
    );

    always #5 clk = ~clk;

    // Memory model: small write log over a per-address default word
    logic [AW-1:0] wlog_a [8];
    logic [WW-1:0] wlog_d [8];
    int            nw = 0;

    function automatic logic [WW-1:0] word_of(input logic [AW-1:0] a);
        logic [WW-1:0] w;
        w = {16'hC0DE, a};
        for (int j = 0; j < 8; j++) begin
            if (j < nw && wlog_a[j] == a) w = wlog_d[j];
        end
        return w;
    endfunction

    function automatic logic [LW-1:0] line_of(input logic [AW-1:0] a);
        return {{15{16'h5A5A, a}}, word_of(a)};
    endfunction

    always @(posedge clk) begin
        if (mem_wrt_en && nw < 8) begin
            wlog_a[nw] <= mem_addr;
            wlog_d[nw] <= mem_wrt_data;
            nw         <= nw + 1;
        end
        if (mem_rd_en) mem_rd_data <= line_of(mem_addr);
    end

    task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        cpu_req = 1'b0; cpu_wrt_en = 1'b0; cpu_addr = '0; cpu_wrt_data = '0;
        accel_req = '0; accel_wrt_en = '0; accel_addr = '0; accel_wrt_data = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle_inputs();
        next_cycle();
        next_cycle();
        rst_n = 1'b1;
    endtask

    logic [AW-1:0] t2_addr [6] = '{16'h0100, 16'h0200, 16'h0101, 16'h0201, 16'h0102, 16'h0202};
    logic [LW-1:0] exp_line;
    bit            forced;

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        sample();
        chk("rst_stall", cpu_stall, 0);
        chk("rst_cpu_vld", cpu_rd_valid, 0);
        chk("rst_acc_vld", accel_rd_valid, 0);
        chk("rst_mem_en", {mem_wrt_en, mem_rd_en}, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_ready", accel_ready, 2'b11);
        chk("rst_acc_data", accel_rd_data, 0);
        do_reset();

        // single accel0 read
        accel_req = 2'b01; accel_addr = {16'h0000, 16'h0010};
        sample();
        chk("t1_no_issue", mem_rd_en, 0);
        next_cycle();
        accel_req = 2'b00;
        sample();
        chk("t1_rd_en", mem_rd_en, 1);
        chk("t1_addr", mem_addr, 16'h0010);
        next_cycle();
        sample();
        chk("t1_vld", accel_rd_valid, 2'b01);
        chk("t1_data", accel_rd_data, line_of(16'h0010));
        next_cycle();
        sample();
        chk("t1_vld_off", accel_rd_valid, 2'b00);

        // round-robin across both FIFOs
        do_reset();
        for (int k = 0; k < 8; k++) begin
            accel_req  = (k < 3) ? 2'b11 : 2'b00;
            accel_addr = {16'h0200 + 16'(k), 16'h0100 + 16'(k)};
            sample();
            if (k >= 1 && k <= 6) begin
                chk("t2_rd_en", mem_rd_en, 1);
                chk("t2_addr", mem_addr, t2_addr[k-1]);
            end
            if (k >= 2) begin
                chk("t2_vld", accel_rd_valid, 2'b01 << ((k - 2) % 2));
                chk("t2_data", accel_rd_data, line_of(t2_addr[k-2]));
            end
            next_cycle();
        end

        // FIFO full with CPU busy: fifth push dropped
        do_reset();
        for (int k = 0; k < 10; k++) begin
            cpu_req    = (k < 5);
            cpu_addr   = 16'h0300;
            accel_req  = {1'b0, k < 5};
            accel_addr = {16'h0000, 16'h0400 + 16'(k)};
            sample();
            chk("t3_stall", cpu_stall, 0);
            if (k >= 1 && k <= 3) chk("t3_ready", accel_ready[0], 1);
            if (k == 4) begin
                chk("t3_full", accel_ready[0], 0);
                chk("t3_cpu_addr", mem_addr, 16'h0300);
            end
            if (k >= 5 && k <= 8) begin
                chk("t3_rd_en", mem_rd_en, 1);
                chk("t3_addr", mem_addr, 16'h0400 + 16'(k - 5));
            end
            if (k == 9) begin
                chk("t3_idle", mem_rd_en, 0);
                chk("t3_ready_end", accel_ready, 2'b11);
            end
            next_cycle();
        end

        // starvation under continuous CPU traffic
        do_reset();
        for (int k = 0; k <= 20; k++) begin
            cpu_req    = (k < 20);
            cpu_addr   = 16'h0500;
            accel_req  = (k == 0) ? 2'b10 : 2'b00;
            accel_addr = {16'h0600, 16'h0000};
            sample();
            forced = GUARD && (k == 9);
            chk("t4_stall", cpu_stall, forced);
            chk("t4_addr", mem_addr, (k < 20) ? (forced ? 16'h0600 : 16'h0500) : (GUARD ? 16'h0000 : 16'h0600));
            chk("t4_rd_en", mem_rd_en, (k < 20) || !GUARD);
            chk("t4_acc_vld", accel_rd_valid, (GUARD && k == 10) ? 2'b10 : 2'b00);
            chk("t4_cpu_vld", cpu_rd_valid, (k >= 1) && !(GUARD && k == 10));
            next_cycle();
        end

        // CPU read-after-write
        do_reset();
        cpu_req = 1'b1; cpu_wrt_en = 1'b1; cpu_addr = 16'h0040; cpu_wrt_data = 32'hDEADBEEF;
        sample();
        chk("t5_wr_en", {mem_wrt_en, mem_rd_en}, 2'b10);
        chk("t5_wr_data", mem_wrt_data, 32'hDEADBEEF);
        chk("t5_wr_addr", mem_addr, 16'h0040);
        next_cycle();
        cpu_wrt_en = 1'b0;
        sample();
        chk("t5_rd_en", {mem_wrt_en, mem_rd_en}, 2'b01);
        chk("t5_no_wr_resp", cpu_rd_valid, 0);
        next_cycle();
        cpu_req = 1'b0;
        sample();
        chk("t5_vld", cpu_rd_valid, 1);
        chk("t5_data", cpu_rd_data, 32'hDEADBEEF);
        chk("t5_acc_vld", accel_rd_valid, 2'b00);

        // accelerator write then read-back
        do_reset();
        accel_req = 2'b10; accel_wrt_en = 2'b10;
        accel_addr = {16'h0800, 16'h0000}; accel_wrt_data = {32'h12345678, 32'h00000000};
        sample();
        next_cycle();
        accel_wrt_en = 2'b00;
        sample();
        chk("t7_wr_en", {mem_wrt_en, mem_rd_en}, 2'b10);
        chk("t7_wr_addr", mem_addr, 16'h0800);
        chk("t7_wr_data", mem_wrt_data, 32'h12345678);
        next_cycle();
        accel_req = 2'b00;
        sample();
        chk("t7_rd_en", {mem_wrt_en, mem_rd_en}, 2'b01);
        next_cycle();
        sample();
        exp_line = {{15{32'h5A5A0800}}, 32'h12345678};
        chk("t7_vld", accel_rd_valid, 2'b10);
        chk("t7_data", accel_rd_data, exp_line);

        // reset while a read is in flight
        do_reset();
        accel_req = 2'b11; accel_addr = {16'h0701, 16'h0700};
        sample();
        next_cycle();
        accel_req = 2'b00;
        sample();
        chk("t6_rd_en", mem_rd_en, 1);
        chk("t6_addr", mem_addr, 16'h0700);
        rst_n = 1'b0;
        next_cycle();
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            sample();
            chk("t6_acc_vld", accel_rd_valid, 2'b00);
            chk("t6_cpu_vld", cpu_rd_valid, 0);
            chk("t6_idle", {mem_wrt_en, mem_rd_en}, 2'b00);
            chk("t6_ready", accel_ready, 2'b11);
            next_cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
